// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined floating-point multiplier with valid/ready flow control.
// Operands are registered on accept, then go through unpack, normalise and round/pack.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_inv,
  output logic                   out_inx
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0] ONES = '1;
  localparam logic [EXP_W-1:0] ONES_M1 = ONES - EXP_W'(1);

  logic advance;
  logic v1, rm1;
  logic [W-1:0] a1, b1;
  logic v2, rm2, spec2, inv2, sgn2;
  logic [W-1:0] sres2;
  logic signed [EW-1:0] e2;
  logic [PW-1:0] prod2;
  logic v3, rm3, spec3, inv3, sgn3, g3, s3;
  logic [W-1:0] sres3;
  logic signed [EW-1:0] e3;
  logic [MAN_W-1:0] man3;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic sa, sb, sgn, za, zb, ia, ib, na, nb, inf_zero, nan;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic [W-1:0] sres;
  logic signed [EW-1:0] e1;
  logic [PW-1:0] prod;
  assign {sa, ea, ma} = a1;
  assign {sb, eb, mb} = b1;
  assign sgn = sa ^ sb;
  // exp = 0 covers both true zero and flushed subnormals
  assign za = ea == '0;
  assign zb = eb == '0;
  assign ia = ea == ONES && ma == '0;
  assign ib = eb == ONES && mb == '0;
  assign na = ea == ONES && ma != '0;
  assign nb = eb == ONES && mb != '0;
  assign inf_zero = (ia && zb) || (ib && za);
  assign nan = na || nb || inf_zero;
  assign sres = nan ? {1'b0, ONES, 1'b1, {(MAN_W-1){1'b0}}}
              : (ia || ib) ? {sgn, ONES, {MAN_W{1'b0}}} : {sgn, {(W-1){1'b0}}};
  assign prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign e1 = EW'(ea) + EW'(eb) - BIAS;

  logic [MAN_W-1:0] n_man;
  logic n_g, n_s;
  logic signed [EW-1:0] n_e;
  assign n_man = prod2[PW-1] ? prod2[PW-2 -: MAN_W] : prod2[PW-3 -: MAN_W];
  assign n_g   = prod2[PW-1] ? prod2[PW-2-MAN_W] : prod2[PW-3-MAN_W];
  assign n_s   = prod2[PW-1] ? |prod2[PW-3-MAN_W:0] : |prod2[PW-4-MAN_W:0];
  assign n_e   = e2 + EW'(prod2[PW-1]);

  logic inc, cy, ovf, unf;
  logic [MAN_W-1:0] rman;
  logic signed [EW-1:0] er;
  logic [W-1:0] res;
  assign inc = !rm3 && g3 && (s3 || man3[0]);
  assign {cy, rman} = {1'b0, man3} + (MAN_W+1)'(inc);
  assign er  = e3 + EW'(cy);
  assign ovf = er >= EMAX;
  assign unf = !ovf && (er[EW-1] || er == '0);
  assign res = spec3 ? sres3
             : ovf ? (rm3 ? {sgn3, ONES_M1, {MAN_W{1'b1}}} : {sgn3, ONES, {MAN_W{1'b0}}})
             : unf ? {sgn3, {(W-1){1'b0}}} : {sgn3, er[EXP_W-1:0], rman};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, rm1, a1, b1} <= '0;
      {v2, rm2, spec2, inv2, sgn2, sres2, e2, prod2} <= '0;
      {v3, rm3, spec3, inv3, sgn3, g3, s3, sres3, e3, man3} <= '0;
      {out_valid, out_res, out_ovf, out_unf, out_inv, out_inx} <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      rm1 <= in_rmode;
      a1 <= in_a;
      b1 <= in_b;
      v2 <= v1;
      rm2 <= rm1;
      spec2 <= nan || ia || ib || za || zb;
      inv2 <= inf_zero || (na && !ma[MAN_W-1]) || (nb && !mb[MAN_W-1]);
      sgn2 <= sgn;
      sres2 <= sres;
      e2 <= e1;
      prod2 <= prod;
      v3 <= v2;
      rm3 <= rm2;
      spec3 <= spec2;
      inv3 <= inv2;
      sgn3 <= sgn2;
      sres3 <= sres2;
      e3 <= n_e;
      man3 <= n_man;
      g3 <= n_g;
      s3 <= n_s;
      out_valid <= v3;
      out_res <= res;
      out_ovf <= !spec3 && ovf;
      out_unf <= !spec3 && unf;
      out_inv <= spec3 && inv3;
      out_inx <= !spec3 && (ovf || unf || g3 || s3);
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed and randomized checks of fp_mult_pipe against an exact-arithmetic model.
module tb_fp_mult_pipe;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_rmode = 0, out_valid, out_ready = 1;
  logic [31:0] in_a = 0, in_b = 0, out_res;
  logic out_ovf, out_unf, out_inv, out_inx;
  logic s_in_valid = 0, s_in_ready, s_in_rmode = 0, s_out_valid;
  logic [15:0] s_in_a = 0, s_in_b = 0, s_out_res;
  logic s_out_ovf, s_out_unf, s_out_inv, s_out_inx;

  int checks = 0, errors = 0, n_in = 0, n_out = 0;
  logic [35:0] expq[$];
  bit was_stall = 0;
  logic [35:0] held;

  always #5 clk = ~clk;

  fp_mult_pipe dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rmode(in_rmode), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_ovf(out_ovf), .out_unf(out_unf), .out_inv(out_inv), .out_inx(out_inx));

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b), .in_rmode(s_in_rmode),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_res(s_out_res), .out_ovf(s_out_ovf),
    .out_unf(s_out_unf), .out_inv(s_out_inv), .out_inx(s_out_inx));

  // Exact product, then round by comparing the discarded remainder with one half.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, b, input bit rm, input int ew, mw);
    longint emax = (longint'(1) << ew) - 1, mmask = (longint'(1) << mw) - 1;
    longint bias = (longint'(1) << (ew - 1)) - 1;
    longint ea = (longint'(a) >> mw) & emax, eb = (longint'(b) >> mw) & emax;
    longint ma = longint'(a) & mmask, mb = longint'(b) & mmask;
    longint sgn = (((longint'(a) ^ longint'(b)) >> (ew + mw)) & 1) << (ew + mw);
    longint p, q, rem, half, e, res;
    int k, sh;
    bit za = ea == 0, zb = eb == 0, ia = ea == emax && ma == 0, ib = eb == emax && mb == 0;
    bit na = ea == emax && ma != 0, nb = eb == emax && mb != 0;
    bit sna = na && ((ma >> (mw - 1)) & 1) == 0, snb = nb && ((mb >> (mw - 1)) & 1) == 0;
    bit iz = (ia && zb) || (ib && za), inx, ovf, unf;
    if (na || nb || iz)
      return {1'b0, iz || sna || snb, 2'b00, 32'((emax << mw) | (longint'(1) << (mw - 1)))};
    if (ia || ib) return {4'b0, 32'(sgn | (emax << mw))};
    if (za || zb) return {4'b0, 32'(sgn)};
    p = ((longint'(1) << mw) | ma) * ((longint'(1) << mw) | mb);
    k = 0;
    while ((p >> (k + 1)) != 0) k++;
    sh = k - mw;
    q = p >> sh;
    rem = p & ((longint'(1) << sh) - 1);
    half = longint'(1) << (sh - 1);
    e = ea + eb - bias + (k - 2 * mw);
    inx = rem != 0;
    if (!rm && (rem > half || (rem == half && (q & 1) != 0))) q++;
    if ((q >> (mw + 1)) != 0) begin
      q = q >> 1;
      e++;
    end
    ovf = e >= emax;
    unf = !ovf && e <= 0;
    res = ovf ? (rm ? (sgn | ((emax - 1) << mw) | mmask) : (sgn | (emax << mw)))
        : unf ? sgn : (sgn | (e << mw) | (q & mmask));
    return {inx || ovf || unf, 1'b0, unf, ovf, 32'(res)};
  endfunction

  function automatic logic [31:0] rnd32();
    int r = $urandom_range(0, 9);
    logic [7:0] e = r == 0 ? 8'h00 : r == 1 ? 8'hFF : r < 5 ? 8'($urandom_range(1, 254))
                  : 8'($urandom_range(100, 154));
    return (r == 2) ? {1'($urandom), 8'hFF, 23'h0} : {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, observe transfers 1ns later, before the rising edge.
  task automatic step(input bit v, input logic [31:0] a, b, input bit rm, input bit ordy,
                      input logic [35:0] ex, output bit acc);
    logic [35:0] obs;
    in_valid = v; in_a = a; in_b = b; in_rmode = rm; out_ready = ordy;
    #1;
    obs = {out_inx, out_inv, out_unf, out_ovf, out_res};
    acc = in_valid && in_ready;
    if (out_valid && !out_ready) begin
      chk("stall_in_ready", 64'(in_ready), 0);
      if (was_stall) chk("stall_hold", 64'(obs), 64'(held));
      held = obs;
      was_stall = 1;
    end else was_stall = 0;
    if (out_valid && out_ready) begin
      n_out++;
      if (expq.size() == 0) chk("spurious_out", 64'(out_valid), 0);
      else chk("result", 64'(obs), 64'(expq.pop_front()));
    end
    if (acc) begin
      expq.push_back(ex);
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] a, b, input bit rm, input logic [35:0] ex);
    s_in_valid = 1; s_in_a = a; s_in_b = b; s_in_rmode = rm;
    @(negedge clk);
    s_in_valid = 0;
    repeat (2) @(negedge clk);
    chk("h_valid_early", 64'(s_out_valid), 0);
    @(negedge clk);
    chk("h_valid", 64'(s_out_valid), 1);
    chk("h_result", 64'({s_out_inx, s_out_inv, s_out_unf, s_out_ovf, 16'h0, s_out_res}), 64'(ex));
  endtask

  logic [31:0] da[12] = '{32'h3F800001, 32'h3F800001, 32'h3FC00000, 32'h7F000000, 32'h7F000000,
    32'h7F800000, 32'hFF800000, 32'h7F800001, 32'h00000001, 32'h00800000, 32'h7FC00000, 32'h80000000};
  logic [31:0] db[12] = '{32'h3F800001, 32'h3F800001, 32'h3FC00000, 32'h40000000, 32'h40000000,
    32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000, 32'h40000000};
  bit drm[12] = '{0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [35:0] dex[12] = '{36'h83F800002, 36'h83F800002, 36'h040100000, 36'h97F800000, 36'h97F7FFFFF,
    36'h47FC00000, 36'h0FF800000, 36'h47FC00000, 36'h000000000, 36'hA00000000, 36'h07FC00000,
    36'h080000000};

  initial begin
    bit acc;
    int idx;
    logic [31:0] pa[6], pb[6];
    bit prm[6];
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_res", 64'({out_inx, out_inv, out_unf, out_ovf, out_res}), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 1);
    // Latency: accept at edge N, visible after edge N+3
    step(1, 32'h40000000, 32'h40400000, 0, 1, 36'h040C00000, acc);
    step(0, 0, 0, 0, 1, 0, acc);
    chk("lat_n1", 64'(out_valid), 0);
    step(0, 0, 0, 0, 1, 0, acc);
    chk("lat_n2", 64'(out_valid), 0);
    step(0, 0, 0, 0, 1, 0, acc);
    chk("lat_n3", 64'(out_valid), 1);
    step(0, 0, 0, 0, 1, 0, acc);
    for (int i = 0; i < 12; i++) step(1, da[i], db[i], drm[i], 1, dex[i], acc);
    repeat (4) step(0, 0, 0, 0, 1, 0, acc);
    chk("directed_drained", 64'(expq.size()), 0);
    // Six back-to-back pairs with a five-cycle consumer stall
    for (int i = 0; i < 6; i++) begin
      pa[i] = rnd32(); pb[i] = rnd32(); prm[i] = 1'($urandom);
    end
    n_in = 0; n_out = 0; idx = 0;
    for (int c = 0; c < 20; c++) begin
      int j = idx < 6 ? idx : 0;
      step(idx < 6, pa[j], pb[j], prm[j], !(c >= 4 && c < 9),
           ref_mul(pa[j], pb[j], prm[j], 8, 23), acc);
      if (acc) idx++;
    end
    chk("stall_in_count", 64'(n_in), 6);
    chk("stall_out_count", 64'(n_out), 6);
    // Random traffic with random backpressure
    n_in = 0; n_out = 0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a = rnd32(), b = rnd32();
      bit rm = 1'($urandom);
      step(1'($urandom), a, b, rm, $urandom_range(0, 3) != 0, ref_mul(a, b, rm, 8, 23), acc);
    end
    repeat (6) step(0, 0, 0, 0, 1, 0, acc);
    chk("rand_drained", 64'(expq.size()), 0);
    chk("rand_count", 64'(n_out), 64'(n_in));
    // Reset while results are in flight
    for (int i = 0; i < 4; i++) step(1, 32'h40000000, 32'h3F800000 + 32'(i), 0, 1, 0, acc);
    repeat (3) step(0, 0, 0, 0, 0, 0, acc);
    chk("pre_rst_valid", 64'(out_valid), 1);
    rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 0);
    chk("async_rst_res", 64'(out_res), 0);
    expq.delete();
    was_stall = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0, acc);
      chk("no_stale", 64'(out_valid), 0);
    end
    step(1, 32'hC0000000, 32'h40400000, 1, 1, 36'h0C0C00000, acc);
    repeat (4) step(0, 0, 0, 0, 1, 0, acc);
    chk("post_rst_drained", 64'(expq.size()), 0);
    // Half-precision-shaped instance
    op16(16'h4000, 16'h4200, 0, 36'h000004600);
    op16(16'h7C00, 16'h0000, 0, 36'h400007E00);
    op16(16'h7800, 16'h4000, 1, {4'b1001, 32'h00007BFF});
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
      logic [15:0] b = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
      bit rm = 1'($urandom);
      op16(a, b, rm, ref_mul({16'h0, a}, {16'h0, b}, rm, 5, 10));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
